cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cacheline width in bits for all data buses.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_read  in  1  I-cache line read request, held high until i_resp.
REQ-006 i_address  in  ADDR_W  I-cache line address.
REQ-007 i_rdata  out  LINE_W  line data returned to I-cache.
REQ-008 i_resp  out  1  one-cycle completion pulse to I-cache.
REQ-009 d_read  in  1  D-cache line read request, held high until d_resp.
REQ-010 d_write  in  1  D-cache line write-back request, held high until d_resp.
REQ-011 d_address  in  ADDR_W  D-cache line address.
REQ-012 d_wdata  in  LINE_W  D-cache write-back data.
REQ-013 d_rdata  out  LINE_W  line data returned to D-cache.
REQ-014 d_resp  out  1  one-cycle completion pulse to D-cache.
REQ-015 pmem_read  out  1  memory read strobe.
REQ-016 pmem_write  out  1  memory write strobe.
REQ-017 pmem_address  out  ADDR_W  memory address.
REQ-018 pmem_wdata  out  LINE_W  memory write data.
REQ-019 pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp.
REQ-020 pmem_resp  in  1  memory completion pulse.

Function
REQ-021 FSM states IDLE, I_BUSY, D_BUSY; exactly one memory transaction outstanding at any time.
REQ-022 IDLE: only i_read pending -> I_BUSY; only d_read/d_write pending -> D_BUSY; none -> stay IDLE.
REQ-023 IDLE with both pending: grant the requester not recorded in last_grant (round robin).
REQ-024 last_grant updates on every grant; last_grant resets to D, so I wins the first conflict.
REQ-025 On grant: latch address, op (read/write) and d_wdata into registers; pmem_* outputs driven from these latches only, stable for the whole transaction.
REQ-026 d_read and d_write both high at grant: write is latched, read ignored.
REQ-027 pmem_read high in I_BUSY and in D_BUSY with latched op read; pmem_write high only in D_BUSY with latched op write; both low in IDLE.
REQ-028 Latency: request seen at edge N in IDLE -> pmem strobe high during cycle N+1.
REQ-029 i_resp = pmem_resp AND state==I_BUSY; d_resp = pmem_resp AND state==D_BUSY; combinational, no added latency.
REQ-030 i_rdata and d_rdata both driven directly from pmem_rdata.
REQ-031 pmem_resp in BUSY -> IDLE at next edge; the requester has deasserted by then, the other requester is evaluated in IDLE.
REQ-032 pmem_resp in IDLE ignored; no resp pulse generated, no state change.
REQ-033 Request deasserted mid-transaction: the transaction still completes; pmem strobes are not withdrawn.
REQ-034 Back-to-back: min one IDLE cycle between pmem_resp and the next strobe.

Reset
REQ-035 rst high: state IDLE, last_grant D, latches 0; pmem_read, pmem_write, i_resp, d_resp = 0 immediately, without waiting for a clock.
REQ-036 Reset mid-transaction abandons the in-flight access; no resp pulse is issued for it.

Verification
REQ-037 i_read=1, addr 0x00000060; pmem_resp after 3 cycles, rdata 0xAA..AA -> pmem_read high with addr 0x60 one cycle after request; i_resp one cycle, i_rdata=0xAA..AA; d_resp stays 0.
REQ-038 d_write=1, addr 0x00001000, wdata 0x1234..; d_address/d_wdata changed mid-transaction -> pmem_write=1, pmem_address=0x1000, pmem_wdata unchanged until pmem_resp; d_resp pulses.
REQ-039 i_read and d_read asserted same cycle after reset -> I served first, then D after one IDLE cycle; next simultaneous conflict -> D is granted over I, then I.
REQ-040 d_read=d_write=1 -> only pmem_write asserted.
REQ-041 rst asserted asynchronously two cycles into D_BUSY -> pmem_write drops before next edge; after release with no requests, state IDLE with no resp pulse.
REQ-042 Spurious pmem_resp while IDLE -> i_resp=d_resp=0; state stays IDLE.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: I-cache, D-cache and physical-memory line buses seen by the arbiter.
interface cache_arbiter_if #(parameter int LINE_W = 256, parameter int ADDR_W = 32);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one memory port between I-cache and D-cache.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  state_t            r_state;
  logic              r_last_d;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;
  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_grant_i = bus.i_read & (~w_d_req | r_last_d);
  assign w_grant_d = w_d_req & (~bus.i_read | ~r_last_d);
  // strobes are latched at grant so they stay stable even if the requester drops out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_d     <= 1'b1;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant_i) begin
        r_state      <= I_BUSY;
        r_last_d     <= 1'b0;
        r_pmem_read  <= 1'b1;
        r_pmem_write <= 1'b0;
        r_addr       <= bus.i_address;
      end else if (w_grant_d) begin
        r_state      <= D_BUSY;
        r_last_d     <= 1'b1;
        r_pmem_read  <= ~bus.d_write;
        r_pmem_write <= bus.d_write;
        r_addr       <= bus.d_address;
        r_wdata      <= bus.d_wdata;
      end
    end else if (bus.pmem_resp) begin
      r_state      <= IDLE;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end
  end
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_addr;
  assign bus.pmem_wdata   = r_wdata;
  assign bus.i_resp       = bus.pmem_resp & (r_state == I_BUSY);
  assign bus.d_resp       = bus.pmem_resp & (r_state == D_BUSY);
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: table-driven arbitration vectors checked through a grant-order scoreboard.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  typedef struct {
    bit          is_d;
    bit          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;
  typedef struct {
    bit          ir;
    bit          dr;
    bit          dw;
    bit          d_first;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [LW-1:0] wd;
    logic [LW-1:0] ird;
    logic [LW-1:0] drd;
    int          lat;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drop_req(input bit is_d);
    if (is_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else bus.i_read = 1'b0;
  endtask

  task automatic serve(input int lat, input bit drop);
    exp_t e;
    int n = 0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.pmem_read || bus.pmem_write) && n < 20);
    chk("grant_latency", n, 1);
    chk("pmem_read", bus.pmem_read, !e.wr);
    chk("pmem_write", bus.pmem_write, e.wr);
    chk("pmem_address", bus.pmem_address, e.addr);
    if (e.wr) chk("pmem_wdata", bus.pmem_wdata, e.wdata);
    if (drop) drop_req(e.is_d);
    for (int k = 0; k < lat; k++) begin
      if (e.is_d) begin
        bus.d_address = $urandom;
        bus.d_wdata   = rnd_line();
      end else bus.i_address = $urandom;
      @(negedge clk);
      chk("hold_strobe", {bus.pmem_read, bus.pmem_write}, {!e.wr, e.wr});
      chk("hold_address", bus.pmem_address, e.addr);
      if (e.wr) chk("hold_wdata", bus.pmem_wdata, e.wdata);
      chk("early_resp", {bus.i_resp, bus.d_resp}, 0);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = e.rdata;
    #1;
    chk("i_resp", bus.i_resp, !e.is_d);
    chk("d_resp", bus.d_resp, e.is_d);
    chk(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = rnd_line();
    drop_req(e.is_d);
    #1;
    chk("idle_gap", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 0);
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t ie;
    exp_t de;
    @(negedge clk);
    bus.i_read    = v.ir;
    bus.i_address = v.ia;
    bus.d_read    = v.dr;
    bus.d_write   = v.dw;
    bus.d_address = v.da;
    bus.d_wdata   = v.wd;
    ie = '{is_d: 1'b0, wr: 1'b0, addr: v.ia, wdata: '0, rdata: v.ird};
    de = '{is_d: 1'b1, wr: v.dw, addr: v.da, wdata: v.wd, rdata: v.drd};
    if (v.ir && (v.dr || v.dw)) begin
      if (v.d_first) begin
        sb.push_back(de);
        sb.push_back(ie);
      end else begin
        sb.push_back(ie);
        sb.push_back(de);
      end
      serve(v.lat, 1'b0);
      serve(v.lat, 1'b0);
    end else begin
      if (v.ir) sb.push_back(ie);
      if (v.dr || v.dw) sb.push_back(de);
      serve(v.lat, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bus.i_read = 0; bus.i_address = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_address = '0; bus.d_wdata = '0; bus.pmem_resp = 0; bus.pmem_rdata = rnd_line();
    vecs[0] = '{ir: 1, dr: 1, dw: 0, d_first: 0, ia: 32'h60, da: 32'h3040, wd: rnd_line(),
                ird: {32{8'hAA}}, drd: rnd_line(), lat: 3};
    vecs[1] = '{ir: 0, dr: 0, dw: 1, d_first: 0, ia: 32'h0, da: 32'h1000, wd: {16{16'h1234}},
                ird: '0, drd: rnd_line(), lat: 3};
    vecs[2] = '{ir: 1, dr: 0, dw: 0, d_first: 0, ia: 32'h80, da: 32'h0, wd: '0,
                ird: rnd_line(), drd: '0, lat: 1};
    vecs[3] = '{ir: 1, dr: 1, dw: 1, d_first: 1, ia: 32'h2000, da: 32'h4000, wd: rnd_line(),
                ird: rnd_line(), drd: rnd_line(), lat: 2};
    vecs[4] = '{ir: 1, dr: 1, dw: 0, d_first: 1, ia: 32'h2100, da: 32'h4100, wd: rnd_line(),
                ird: rnd_line(), drd: rnd_line(), lat: 2};
    vecs[5] = '{ir: 0, dr: 1, dw: 0, d_first: 0, ia: 32'h0, da: 32'h5000, wd: '0,
                ird: '0, drd: rnd_line(), lat: 0};
    #1 rst = 1'b1;
    #1;
    chk("reset_pmem_read", bus.pmem_read, 0);
    chk("reset_pmem_write", bus.pmem_write, 0);
    chk("reset_resps", {bus.i_resp, bus.d_resp}, 0);
    chk("reset_address", bus.pmem_address, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) apply_vec(vecs[i]);
    @(negedge clk);
    bus.i_read    = 1'b1;
    bus.i_address = 32'h700;
    e = '{is_d: 1'b0, wr: 1'b0, addr: 32'h700, wdata: '0, rdata: rnd_line()};
    sb.push_back(e);
    serve(3, 1'b1);
    @(negedge clk);
    bus.d_write   = 1'b1;
    bus.d_address = 32'h9000;
    bus.d_wdata   = rnd_line();
    @(negedge clk);
    chk("abort_strobe", bus.pmem_write, 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_pmem_write", bus.pmem_write, 0);
    chk("abort_resps", {bus.i_resp, bus.d_resp}, 0);
    bus.d_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_idle", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 0);
    end
    bus.pmem_resp = 1'b1;
    #1;
    chk("spurious_resp", {bus.i_resp, bus.d_resp}, 0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    chk("spurious_idle", {bus.pmem_read, bus.pmem_write}, 0);
    apply_vec(vecs[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
